memory_burst_controller: RTL and testbench

// - Upstream driver for finite_state_machine + memory_unit (8x8 byte store, 3-bit addr, rw from the FSM).
// - Accepts a byte stream on a valid/ready port and writes it to consecutive addresses from 0.
// - On request, reads back every byte written and emits it on a valid/last stream.
// - Owns mem_addr, mem_in, fsm_r and fsm_w. Consumes mem_out.

---
 rtl/mem_ctrl_pkg.sv | 23 ++
 rtl/burst_addr_counter.sv | 37 +++
 rtl/memory_burst_controller.sv | 163 ++++++++++++++++
 tb/tb_memory_burst_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory burst controller: default widths and FSM state codes.
package mem_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_SETTLE = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WRITE = 3'd1;
  localparam logic [2:0] S_FULL  = 3'd2;
  localparam logic [2:0] S_SETUP = 3'd3;
  localparam logic [2:0] S_READ  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    WRITE = S_WRITE,
    FULL  = S_FULL,
    SETUP = S_SETUP,
    READ  = S_READ
  } state_t;

endpackage

// File: rtl/burst_addr_counter.sv
// Up-counter with synchronous clear and enable that wraps to 0 after DEPTH-1.
module burst_addr_counter
  import mem_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Clear wins over enable.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/memory_burst_controller.sv
// Streams bytes into an external 8-word memory from address 0, then reads the burst back on request.
module memory_burst_controller
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_start,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out,
  output logic              fsm_w,
  output logic              fsm_r,
  output logic [2:0]        dbg_state
);

  localparam logic [ADDR_W:0]   CNT_ONE     = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE    = ADDR_W'(1);
  localparam logic [1:0]        SETTLE_LAST = 2'(SETTLE - 1);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_in_q, mem_in_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic [1:0]        settle_q, settle_d;
  logic              fsm_w_q, fsm_w_d, fsm_r_q, fsm_r_d;
  logic              rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_hs, rd_go, word_done, last_word, can_write;

  // wr_data is consumed on any edge where wr_valid && wr_ready; rd_start wins over a same-cycle write.
  assign can_write = (state_q == S_IDLE) || (state_q == S_WRITE);
  assign wr_ready  = !rst && can_write && (count_q < CNT_FULL) && !rd_start;
  assign wr_hs     = wr_valid && wr_ready;
  assign rd_go     = rd_start && (count_q != '0) && (can_write || state_q == S_FULL);
  assign word_done = (state_q == S_READ) && (settle_q == SETTLE_LAST);
  assign last_word = word_done && (({1'b0, rd_ptr} + CNT_ONE) == count_q);

  burst_addr_counter #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (last_word),
    .en_i  (wr_hs),
    .cnt_o (wr_ptr)
  );

  burst_addr_counter #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clr_i (last_word),
    .en_i  (word_done),
    .cnt_o (rd_ptr)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    mem_in_d   = mem_in_q;
    rd_data_d  = rd_data_q;
    settle_d   = settle_q;
    fsm_w_d    = fsm_w_q;
    fsm_r_d    = fsm_r_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    if (rd_go) begin
      state_d    = S_SETUP;
      fsm_w_d    = 1'b0;
      fsm_r_d    = 1'b1;
      mem_addr_d = '0;
      settle_d   = '0;
    end else begin
      case (state_q)
        S_IDLE, S_WRITE: begin
          if (wr_hs) begin
            mem_addr_d = wr_ptr;
            mem_in_d   = wr_data;
            fsm_w_d    = 1'b1;
            count_d    = count_q + CNT_ONE;
            state_d    = (count_d == CNT_FULL) ? S_FULL : S_WRITE;
          end
        end
        // fsm_w stays high for the cycle after the final write so that byte still lands.
        S_FULL:  fsm_w_d = 1'b0;
        S_SETUP: begin
          state_d  = S_READ;
          settle_d = '0;
        end
        S_READ: begin
          if (word_done) begin
            rd_data_d  = mem_out;
            rd_valid_d = 1'b1;
            rd_last_d  = last_word;
            settle_d   = '0;
            if (last_word) begin
              state_d    = S_IDLE;
              count_d    = '0;
              fsm_r_d    = 1'b0;
              mem_addr_d = '0;
            end else begin
              mem_addr_d = rd_ptr + ADDR_ONE;
            end
          end else begin
            settle_d = settle_q + 2'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      count_q    <= '0;
      mem_addr_q <= '0;
      mem_in_q   <= '0;
      rd_data_q  <= '0;
      settle_q   <= '0;
      fsm_w_q    <= 1'b0;
      fsm_r_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      mem_addr_q <= mem_addr_d;
      mem_in_q   <= mem_in_d;
      rd_data_q  <= rd_data_d;
      settle_q   <= settle_d;
      fsm_w_q    <= fsm_w_d;
      fsm_r_q    <= fsm_r_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign rd_last   = rd_last_q;
  assign busy      = (state_q == S_SETUP) || (state_q == S_READ);
  assign count     = count_q;
  assign mem_addr  = mem_addr_q;
  assign mem_in    = mem_in_q;
  assign fsm_w     = fsm_w_q;
  assign fsm_r     = fsm_r_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_burst_controller.sv
// Bench for memory_burst_controller: table-driven bursts, directed corner cases and random traffic.
module tb_memory_burst_controller;
  import mem_ctrl_pkg::*;

  localparam int DEPTH = DEF_DEPTH;

  logic       clk = 1'b0;
  logic       rst = 1'b1, wr_valid = 1'b0, rd_start = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       wr_ready, rd_valid, rd_last, busy, fsm_w, fsm_r;
  logic [7:0] rd_data, mem_in, mem_out;
  logic [3:0] count;
  logic [2:0] mem_addr, dbg_state;
  logic [7:0] mem1 [8];

  logic       rst2 = 1'b1, wr_valid2 = 1'b0, rd_start2 = 1'b0;
  logic [7:0] wr_data2 = 8'h00;
  logic       wr_ready2, rd_valid2, rd_last2, busy2, fsm_w2, fsm_r2;
  logic [7:0] rd_data2, mem_in2, mem_out2;
  logic [3:0] count2;
  logic [2:0] mem_addr2, dbg_state2;
  logic [7:0] mem2 [8];

  int vectors = 0, miscompares = 0, cyc = 0;

  // Reference model: bytes stored since the last readback, and the words still owed.
  logic [7:0] stored[$];
  logic [8:0] exp_q[$];
  int         exp_t_q[$];
  int         busy_left = 0, read_n = 0;

  memory_burst_controller #(.SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_start(rd_start), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .count(count), .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out),
    .fsm_w(fsm_w), .fsm_r(fsm_r), .dbg_state(dbg_state)
  );

  memory_burst_controller #(.SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst2), .wr_valid(wr_valid2), .wr_data(wr_data2), .wr_ready(wr_ready2),
    .rd_start(rd_start2), .rd_valid(rd_valid2), .rd_data(rd_data2), .rd_last(rd_last2),
    .busy(busy2), .count(count2), .mem_addr(mem_addr2), .mem_in(mem_in2), .mem_out(mem_out2),
    .fsm_w(fsm_w2), .fsm_r(fsm_r2), .dbg_state(dbg_state2)
  );

  // Clock/reset block plus simple memories standing in for memory_unit.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (fsm_w)  mem1[mem_addr]  <= mem_in;
  always @(posedge clk) if (fsm_w2) mem2[mem_addr2] <= mem_in2;
  assign mem_out  = mem1[mem_addr];
  assign mem_out2 = mem2[mem_addr2];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every rd_valid pulse must match the oldest owed word and its cycle.
  always @(negedge clk) begin : scoreboard
    logic [8:0] w;
    int t;
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_unexpected: got word %0h, expected no word", rd_data);
      end else begin
        w = exp_q.pop_front();
        t = exp_t_q.pop_front();
        chk("rd_word", {23'd0, rd_last, rd_data}, {23'd0, w});
        chk("rd_cycle", cyc, t);
      end
    end
  end

  // Driver: apply one cycle of inputs, check wr_ready, clock, advance the model, check busy/count.
  task automatic step(input logic wv, input logic [7:0] wd, input logic rs, input logic r);
    logic exp_ready, acc, go;
    int   exp_count;
    wr_valid = wv; wr_data = wd; rd_start = rs; rst = r;
    #1;
    exp_ready = !r && busy_left == 0 && stored.size() < DEPTH && !rs;
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_ready});
    acc = wv && exp_ready;
    go  = rs && !r && busy_left == 0 && stored.size() > 0;
    @(posedge clk); #1;
    if (r) begin
      stored.delete(); exp_q.delete(); exp_t_q.delete();
      busy_left = 0; read_n = 0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) read_n = 0;
      end
      if (acc) stored.push_back(wd);
      if (go) begin
        read_n = stored.size();
        for (int i = 0; i < read_n; i++) begin
          exp_q.push_back({(i == read_n - 1), stored[i]});
          exp_t_q.push_back(cyc + 1 + (i + 1) * 1);
        end
        stored.delete();
        busy_left = 1 + read_n * 1;
      end
    end
    exp_count = (busy_left > 0) ? read_n : stored.size();
    chk("busy", {31'd0, busy}, (busy_left > 0) ? 32'd1 : 32'd0);
    chk("count", {28'd0, count}, exp_count);
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && busy_left > 0; k++) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    chk("words_missing", exp_q.size(), 0);
  endtask

  typedef struct {
    int         n;
    int         gap;
    logic [7:0] b [9];
    logic [3:0] exp_count;
    logic [2:0] exp_state;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] karl [8] = '{8'h4B, 8'h61, 8'h72, 8'h6C, 8'h21, 8'h21, 8'h21, 8'h21};

  initial begin
    vecs[0].n = 3; vecs[0].gap = 2; vecs[0].exp_count = 4'd3; vecs[0].exp_state = S_WRITE;
    vecs[0].b = '{8'hA1, 8'hB2, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[1].n = 9; vecs[1].gap = 0; vecs[1].exp_count = 4'd8; vecs[1].exp_state = S_FULL;
    vecs[1].b = '{8'h4B, 8'h61, 8'h72, 8'h6C, 8'h21, 8'h21, 8'h21, 8'h21, 8'hEE};
    vecs[2].n = 1; vecs[2].gap = 0; vecs[2].exp_count = 4'd1; vecs[2].exp_state = S_WRITE;
    vecs[2].b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].n = 6; vecs[3].gap = 1; vecs[3].exp_count = 4'd6; vecs[3].exp_state = S_WRITE;
    vecs[3].b = '{8'h01, 8'hFF, 8'h80, 8'h7F, 8'h3C, 8'hC3, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) begin mem1[i] = 8'h00; mem2[i] = 8'h00; end

    // Reset values.
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    chk("rst_rd_valid", {31'd0, rd_valid}, 0);
    chk("rst_rd_data", {24'd0, rd_data}, 0);
    chk("rst_rd_last", {31'd0, rd_last}, 0);
    chk("rst_mem_addr", {29'd0, mem_addr}, 0);
    chk("rst_mem_in", {24'd0, mem_in}, 0);
    chk("rst_fsm_w", {31'd0, fsm_w}, 0);
    chk("rst_fsm_r", {31'd0, fsm_r}, 0);
    chk("rst_state", {29'd0, dbg_state}, S_IDLE);

    // "Karl!!!!" back-to-back: one address per cycle with fsm_w high.
    for (int i = 0; i < 8; i++) begin
      step(1, karl[i], 0, 0);
      chk("karl_addr", {29'd0, mem_addr}, i);
      chk("karl_in", {24'd0, mem_in}, {24'd0, karl[i]});
      chk("karl_fsm_w", {31'd0, fsm_w}, 1);
    end
    chk("karl_full", {29'd0, dbg_state}, S_FULL);
    for (int i = 0; i < 3; i++) step(1, 8'hEE, 0, 0);
    chk("full_fsm_w", {31'd0, fsm_w}, 0);
    step(0, 8'h00, 1, 0);
    chk("setup_state", {29'd0, dbg_state}, S_SETUP);
    chk("setup_fsm_r", {31'd0, fsm_r}, 1);
    chk("setup_fsm_w", {31'd0, fsm_w}, 0);
    chk("setup_addr", {29'd0, mem_addr}, 0);
    drain();
    chk("idle_fsm_r", {31'd0, fsm_r}, 0);
    chk("idle_state", {29'd0, dbg_state}, S_IDLE);
    chk("rd_data_hold", {24'd0, rd_data}, 32'h21);

    // rd_start with nothing stored is ignored.
    step(0, 8'h00, 1, 0);
    chk("empty_rd_state", {29'd0, dbg_state}, S_IDLE);
    chk("empty_rd_fsm_r", {31'd0, fsm_r}, 0);

    // rd_start beats a same-cycle write.
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h33, 1, 0);
    chk("prio_state", {29'd0, dbg_state}, S_SETUP);
    drain();

    // Reset in the middle of a readback, right after the third word.
    for (int i = 0; i < 5; i++) step(1, 8'hD0 + 8'(i), 0, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 1);
    chk("abort_rd_valid", {31'd0, rd_valid}, 0);
    chk("abort_fsm_r", {31'd0, fsm_r}, 0);
    chk("abort_state", {29'd0, dbg_state}, S_IDLE);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);

    // Table of write bursts followed by a readback.
    for (int v = 0; v < 4; v++) begin
      for (int j = 0; j < vecs[v].n; j++) begin
        step(1, vecs[v].b[j], 0, 0);
        for (int g = 0; g < vecs[v].gap; g++) step(0, 8'h00, 0, 0);
      end
      chk("vec_count", {28'd0, count}, {28'd0, vecs[v].exp_count});
      chk("vec_state", {29'd0, dbg_state}, {29'd0, vecs[v].exp_state});
      step(0, 8'h00, 1, 0);
      drain();
      chk("vec_done", {29'd0, dbg_state}, S_IDLE);
    end

    // Random traffic against the model.
    for (int k = 0; k < 800; k++) begin
      logic       r, wv, rs;
      logic [7:0] d;
      r  = ($urandom_range(0, 63) == 0);
      wv = ($urandom_range(0, 2) != 0);
      rs = ($urandom_range(0, 11) == 0);
      d  = 8'($urandom_range(0, 255));
      step(wv, d, rs, r);
    end
    drain();

    // SETTLE=2 instance: words every second cycle, first one 3 edges after rd_start.
    rst2 = 1'b1;
    @(posedge clk); #1;
    rst2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid2 = 1'b1; wr_data2 = karl[i];
      #1;
      chk("s2_wr_ready", {31'd0, wr_ready2}, 1);
      @(posedge clk); #1;
    end
    wr_valid2 = 1'b0;
    rd_start2 = 1'b1;
    @(posedge clk); #1;
    rd_start2 = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      logic ev;
      @(posedge clk); #1;
      ev = (k >= 3) && (k <= 9) && ((k - 1) % 2 == 0);
      chk("s2_valid", {31'd0, rd_valid2}, {31'd0, ev});
      if (ev) begin
        chk("s2_data", {24'd0, rd_data2}, {24'd0, karl[(k - 1) / 2 - 1]});
        chk("s2_last", {31'd0, rd_last2}, (k == 9) ? 32'd1 : 32'd0);
      end
    end
    chk("s2_busy", {31'd0, busy2}, 0);
    chk("s2_count", {28'd0, count2}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
